// File: rtl/bash_io_pkg.sv
// Shared types and constants for the bash line port.
// Optional feature macro: BASH_PROMPT_EN adds the PROMPT state ("> " prompt).
package bash_io_pkg;

    localparam int unsigned DEF_MAX_LEN = 32;

    localparam logic [7:0] NUL       = 8'h00;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] PROMPT_CH = 8'h3E;

    typedef enum logic [2:0] {
        EDIT,
        SEND,
        WAIT_RESP,
`ifdef BASH_PROMPT_EN
        PROMPT,
`endif
        PRINT
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/bash_line_buf.sv
// Line storage for the bash line port: MAX_LEN x 8 array plus length counter.
// Push appends at buf[len] unless full, pop drops the last char unless empty.
module bash_line_buf
    import bash_io_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             clear,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic [LEN_W-1:0] len,
    output logic             full,
    output logic             empty
);

    logic [7:0] mem [MAX_LEN];

    assign full    = (len == LEN_W'(MAX_LEN - 1));
    assign empty   = (len == '0);
    assign rd_data = mem[rd_idx];

    // Character storage; contents beyond len are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[len] <= push_data;
        end
    end

    // Length counter: clear wins, then push, then pop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            len <= '0;
        end else if (clear) begin
            len <= '0;
        end else if (push && !full) begin
            len <= len + LEN_W'(1);
        end else if (pop && !empty) begin
            len <= len - LEN_W'(1);
        end
    end

endmodule

// File: rtl/bash_line_port.sv
// Bash line port: edits a keyboard line with echo, sends it to the command
// stage, then prints the response to the screen writer.
// Optional feature macro: BASH_PROMPT_EN emits "> " after reset and after
// every completed command.
module bash_line_port
    import bash_io_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_ascii,
    output logic       kbd_ready,
    output logic       out_newASCII_ready,
    output logic [7:0] lineOut,
    output logic [5:0] out_lineLen,
    input  logic       lineOut_nextASCII,
    input  logic       in_newASCII_ready,
    input  logic [7:0] lineIn,
    output logic       lineIn_nextASCII,
    input  logic       in_solved,
    output logic       out_solved,
    output logic [7:0] scr_char,
    output logic       scr_we,
    input  logic       scr_ready
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN);

`ifdef BASH_PROMPT_EN
    localparam state_t RESET_STATE = PROMPT;
    localparam state_t DONE_STATE  = PROMPT;
`else
    localparam state_t RESET_STATE = EDIT;
    localparam state_t DONE_STATE  = EDIT;
`endif

    state_t           state;
    logic             active;
    logic [LEN_W-1:0] idx;
    logic             nx_prev;
    logic             solved_q;
    logic             nl_pend;
`ifdef BASH_PROMPT_EN
    logic             prompt_second;
    logic             prompt_fire;
`endif

    logic             key_acc;
    logic             push;
    logic             pop;
    logic             enter;
    logic             clear;
    logic             print_fire;
    logic             lf_fire;
    logic [7:0]       rd_data;
    logic [LEN_W-1:0] len;
    logic             full;
    logic             empty;

    // active holds every output low until the first edge after reset release.
    // nl_pend blocks keys until the post-response newline has reached the
    // screen, so the newline and a key echo never compete for scr_we.
    assign kbd_ready = active && (state == EDIT) && scr_ready && !nl_pend;
    assign key_acc   = kbd_ready && kbd_valid;
    assign push      = key_acc && is_printable(kbd_ascii);
    assign pop       = key_acc && (kbd_ascii == BS);
    assign enter     = key_acc && ((kbd_ascii == CR) || (kbd_ascii == LF));
    assign clear     = (state == PRINT) && in_solved;

    assign print_fire = active && (state == PRINT) && !in_solved &&
                        (lineIn != NUL) && scr_ready && !nx_prev;
    assign lf_fire    = nl_pend && scr_ready;
`ifdef BASH_PROMPT_EN
    assign prompt_fire = active && (state == PROMPT) && scr_ready && !nl_pend;
`endif

    assign lineIn_nextASCII   = print_fire;
    assign out_solved         = solved_q;
    assign out_newASCII_ready = (state == SEND);
    assign out_lineLen        = (state == SEND) ? 6'(len) : '0;
    assign lineOut            = ((state == SEND) && (idx < len)) ? rd_data : NUL;

    bash_line_buf #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_buf (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (kbd_ascii),
        .pop       (pop),
        .clear     (clear),
        .rd_idx    (idx),
        .rd_data   (rd_data),
        .len       (len),
        .full      (full),
        .empty     (empty)
    );

    // Screen stream mux: at most one source can fire in any cycle.
    always_comb begin
        scr_we   = 1'b0;
        scr_char = NUL;
        if (lf_fire) begin
            scr_we   = 1'b1;
            scr_char = LF;
        end else if (print_fire) begin
            scr_we   = 1'b1;
            scr_char = lineIn;
`ifdef BASH_PROMPT_EN
        end else if (prompt_fire) begin
            scr_we   = 1'b1;
            scr_char = prompt_second ? SPACE : PROMPT_CH;
`endif
        end else if (push && !full) begin
            scr_we   = 1'b1;
            scr_char = kbd_ascii;
        end else if (pop && !empty) begin
            scr_we   = 1'b1;
            scr_char = BS;
        end else if (enter) begin
            scr_we   = 1'b1;
            scr_char = LF;
        end
    end

    // Main control FSM: edit, send, wait for response, print response.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= RESET_STATE;
            active   <= 1'b0;
            idx      <= '0;
            nx_prev  <= 1'b0;
            solved_q <= 1'b0;
            nl_pend  <= 1'b0;
`ifdef BASH_PROMPT_EN
            prompt_second <= 1'b0;
`endif
        end else begin
            active   <= 1'b1;
            nx_prev  <= print_fire;
            solved_q <= 1'b0;
            if (lf_fire) begin
                nl_pend <= 1'b0;
            end
            case (state)
                EDIT: begin
                    if (enter) begin
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (lineOut_nextASCII) begin
                        if (idx < len) begin
                            idx <= idx + LEN_W'(1);
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (in_newASCII_ready) begin
                        state <= PRINT;
                    end
                end
                PRINT: begin
                    if (in_solved) begin
                        solved_q <= 1'b1;
                        nl_pend  <= 1'b1;
                        state    <= DONE_STATE;
                    end
                end
`ifdef BASH_PROMPT_EN
                PROMPT: begin
                    if (prompt_fire) begin
                        if (!prompt_second) begin
                            prompt_second <= 1'b1;
                        end else begin
                            prompt_second <= 1'b0;
                            state         <= EDIT;
                        end
                    end
                end
`endif
                default: state <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_bash_line_port.sv
// Directed self-checking bench for bash_line_port (default build, no prompt).
module tb_bash_line_port;

    logic       clk = 1'b0;
    logic       clrn;
    logic       kbd_valid;
    logic [7:0] kbd_ascii;
    logic       kbd_ready;
    logic       out_newASCII_ready;
    logic [7:0] lineOut;
    logic [5:0] out_lineLen;
    logic       lineOut_nextASCII;
    logic       in_newASCII_ready;
    logic [7:0] lineIn;
    logic       lineIn_nextASCII;
    logic       in_solved;
    logic       out_solved;
    logic [7:0] scr_char;
    logic       scr_we;
    logic       scr_ready;

    int checks = 0;
    int errors = 0;
    int solved_cycles = 0;
    logic [7:0] scr_log [$];
    logic [7:0] line_q [$];
    bit line_ok;
    bit resp_ok;

    bash_line_port #(.MAX_LEN(32)) dut (
        .clk                (clk),
        .clrn               (clrn),
        .kbd_valid          (kbd_valid),
        .kbd_ascii          (kbd_ascii),
        .kbd_ready          (kbd_ready),
        .out_newASCII_ready (out_newASCII_ready),
        .lineOut            (lineOut),
        .out_lineLen        (out_lineLen),
        .lineOut_nextASCII  (lineOut_nextASCII),
        .in_newASCII_ready  (in_newASCII_ready),
        .lineIn             (lineIn),
        .lineIn_nextASCII   (lineIn_nextASCII),
        .in_solved          (in_solved),
        .out_solved         (out_solved),
        .scr_char           (scr_char),
        .scr_we             (scr_we),
        .scr_ready          (scr_ready)
    );

    always #5 clk = ~clk;

    // Screen / solved monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (scr_we) begin
            scr_log.push_back(scr_char);
            checks++;
            if (scr_ready !== 1'b1) begin
                $display("FAIL scr_we_gate: scr_we=1 while scr_ready=%b, required scr_ready=1", scr_ready);
                errors++;
            end
        end
        if (out_solved === 1'b1) solved_cycles++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] b);
        kbd_valid = 1'b1;
        kbd_ascii = b;
        tick();
        kbd_valid = 1'b0;
        kbd_ascii = 8'h00;
    endtask

    // Act as the command stage reading the line; collects bytes into line_q.
    task automatic drain_line;
        int t;
        line_q.delete();
        t = 0;
        while (out_newASCII_ready === 1'b1 && t < 64) begin
            line_q.push_back(lineOut);
            lineOut_nextASCII = 1'b1;
            tick();
            lineOut_nextASCII = 1'b0;
            tick();
            t++;
        end
        line_ok = (t < 64);
    endtask

    // Act as the command stage returning string s, then signalling solved.
    task automatic respond(input string s);
        int i;
        bit done;
        logic nx;
        in_newASCII_ready = 1'b1;
        tick();
        in_newASCII_ready = 1'b0;
        i = 0;
        done = (s.len() == 0);
        lineIn = done ? 8'h00 : s[0];
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            nx = lineIn_nextASCII;
            @(posedge clk);
            #1;
            if (nx) begin
                i++;
                lineIn = (i < s.len()) ? s[i] : 8'h00;
                if (i == s.len()) done = 1'b1;
            end
        end
        resp_ok = done;
        in_solved = 1'b1;
        tick();
        in_solved = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        tick();
        tick();
        checks++;
        if ({kbd_ready, scr_we, scr_char, out_newASCII_ready, lineOut, out_lineLen,
             lineIn_nextASCII, out_solved} !== 28'h0) begin
            $display("FAIL reset_outputs: kbd_ready=%b scr_we=%b scr_char=%h nr=%b lineOut=%h len=%0d nx=%b solved=%b, required all 0",
                     kbd_ready, scr_we, scr_char, out_newASCII_ready, lineOut, out_lineLen,
                     lineIn_nextASCII, out_solved);
            errors++;
        end
        clrn = 1'b1;
        tick();
        checks++;
        if (kbd_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: kbd_ready=%b required 1", kbd_ready);
            errors++;
        end
    endtask

    task automatic test_type_ab;
        logic [7:0] exp_scr [3] = '{8'h61, 8'h62, 8'h0A};
        logic [7:0] exp_line [3] = '{8'h61, 8'h62, 8'h00};
        scr_log.delete();
        key(8'h61); key(8'h62); key(8'h0D);
        checks++;
        if (scr_log.size() != 3) begin
            $display("FAIL ab_echo_count: got %0d required 3", scr_log.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (scr_log[i] !== exp_scr[i]) begin
                    $display("FAIL ab_echo[%0d]: got %h required %h", i, scr_log[i], exp_scr[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (out_newASCII_ready !== 1'b1 || out_lineLen !== 6'd2) begin
            $display("FAIL ab_send: ready=%b len=%0d required ready=1 len=2", out_newASCII_ready, out_lineLen);
            errors++;
        end
        drain_line();
        checks++;
        if (!line_ok || line_q.size() != 3) begin
            $display("FAIL ab_line_count: got %0d required 3", line_q.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (line_q[i] !== exp_line[i]) begin
                    $display("FAIL ab_line[%0d]: got %h required %h", i, line_q[i], exp_line[i]);
                    errors++;
                end
            end
        end
        respond("");
        checks++;
        if (!resp_ok || kbd_ready !== 1'b1) begin
            $display("FAIL ab_back_to_edit: resp_ok=%b kbd_ready=%b required 1 1", resp_ok, kbd_ready);
            errors++;
        end
    endtask

    task automatic test_backspace;
        logic [7:0] exp_scr [5] = '{8'h61, 8'h62, 8'h63, 8'h08, 8'h0A};
        logic [7:0] exp_line [3] = '{8'h61, 8'h62, 8'h00};
        scr_log.delete();
        key(8'h61); key(8'h62); key(8'h63); key(8'h08); key(8'h0D);
        checks++;
        if (scr_log.size() != 5) begin
            $display("FAIL bs_echo_count: got %0d required 5", scr_log.size());
            errors++;
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (scr_log[i] !== exp_scr[i]) begin
                    $display("FAIL bs_echo[%0d]: got %h required %h", i, scr_log[i], exp_scr[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (out_lineLen !== 6'd2) begin
            $display("FAIL bs_len: got %0d required 2", out_lineLen);
            errors++;
        end
        drain_line();
        checks++;
        if (line_q.size() != 3) begin
            $display("FAIL bs_line_count: got %0d required 3", line_q.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (line_q[i] !== exp_line[i]) begin
                    $display("FAIL bs_line[%0d]: got %h required %h", i, line_q[i], exp_line[i]);
                    errors++;
                end
            end
        end
        respond("");
    endtask

    task automatic test_empty_and_backpressure;
        scr_log.delete();
        key(8'h08);
        checks++;
        if (scr_log.size() != 0) begin
            $display("FAIL bs_empty_echo: got %0d echoes required 0", scr_log.size());
            errors++;
        end
        scr_ready = 1'b0;
        #1;
        checks++;
        if (kbd_ready !== 1'b0) begin
            $display("FAIL bp_kbd_ready: got %b required 0", kbd_ready);
            errors++;
        end
        kbd_valid = 1'b1;
        kbd_ascii = 8'h7A;
        tick();
        tick();
        kbd_valid = 1'b0;
        scr_ready = 1'b1;
        checks++;
        if (scr_log.size() != 0) begin
            $display("FAIL bp_no_echo: got %0d echoes required 0", scr_log.size());
            errors++;
        end
        key(8'h0D);
        checks++;
        if (scr_log.size() != 1 || scr_log[0] !== 8'h0A) begin
            $display("FAIL empty_enter_echo: count=%0d required 1 x 0a", scr_log.size());
            errors++;
        end
        checks++;
        if (out_newASCII_ready !== 1'b1 || out_lineLen !== 6'd0 || lineOut !== 8'h00) begin
            $display("FAIL empty_send: ready=%b len=%0d lineOut=%h required 1 0 00",
                     out_newASCII_ready, out_lineLen, lineOut);
            errors++;
        end
        drain_line();
        checks++;
        if (line_q.size() != 1) begin
            $display("FAIL empty_line_count: got %0d required 1", line_q.size());
            errors++;
        end
        respond("");
    endtask

    task automatic test_overflow;
        scr_log.delete();
        for (int k = 0; k < 35; k++) key(8'h41 + 8'(k % 26));
        checks++;
        if (scr_log.size() != 31) begin
            $display("FAIL ovf_echo_count: got %0d required 31", scr_log.size());
            errors++;
        end
        key(8'h0D);
        checks++;
        if (out_lineLen !== 6'd31) begin
            $display("FAIL ovf_len: got %0d required 31", out_lineLen);
            errors++;
        end
        drain_line();
        checks++;
        if (line_q.size() != 32) begin
            $display("FAIL ovf_line_count: got %0d required 32", line_q.size());
            errors++;
        end else begin
            checks++;
            if (line_q[30] !== 8'h45 || line_q[31] !== 8'h00) begin
                $display("FAIL ovf_line_tail: got %h %h required 45 00", line_q[30], line_q[31]);
                errors++;
            end
        end
        respond("");
    endtask

    task automatic test_response;
        logic [7:0] exp_scr [3] = '{8'h68, 8'h69, 8'h0A};
        key(8'h6C); key(8'h73); key(8'h0D);
        drain_line();
        scr_log.delete();
        solved_cycles = 0;
        respond("hi");
        checks++;
        if (!resp_ok) begin
            $display("FAIL resp_timeout: response not consumed, required completion");
            errors++;
        end
        checks++;
        if (scr_log.size() != 3) begin
            $display("FAIL resp_count: got %0d required 3", scr_log.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (scr_log[i] !== exp_scr[i]) begin
                    $display("FAIL resp_scr[%0d]: got %h required %h", i, scr_log[i], exp_scr[i]);
                    errors++;
                end
            end
        end
        tick();
        checks++;
        if (solved_cycles != 1) begin
            $display("FAIL solved_pulse: high %0d cycles required 1", solved_cycles);
            errors++;
        end
        checks++;
        if (kbd_ready !== 1'b1) begin
            $display("FAIL resp_edit: kbd_ready=%b required 1", kbd_ready);
            errors++;
        end
    endtask

    task automatic test_reset_mid_send;
        key(8'h61); key(8'h62); key(8'h0D);
        lineOut_nextASCII = 1'b1;
        tick();
        lineOut_nextASCII = 1'b0;
        checks++;
        if (lineOut !== 8'h62) begin
            $display("FAIL mid_send_idx1: lineOut=%h required 62", lineOut);
            errors++;
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (out_newASCII_ready !== 1'b0) begin
            $display("FAIL mid_send_reset_ready: got %b required 0", out_newASCII_ready);
            errors++;
        end
        tick();
        clrn = 1'b1;
        tick();
        scr_log.delete();
        lineOut_nextASCII = 1'b1;
        tick(); tick(); tick();
        lineOut_nextASCII = 1'b0;
        checks++;
        if (out_newASCII_ready !== 1'b0 || lineOut !== 8'h00 || lineIn_nextASCII !== 1'b0 ||
            scr_log.size() != 0) begin
            $display("FAIL mid_send_after: ready=%b lineOut=%h nx=%b scr=%0d required 0 00 0 0",
                     out_newASCII_ready, lineOut, lineIn_nextASCII, scr_log.size());
            errors++;
        end
        key(8'h0D);
        checks++;
        if (out_lineLen !== 6'd0 || lineOut !== 8'h00) begin
            $display("FAIL mid_send_len: len=%0d lineOut=%h required 0 00", out_lineLen, lineOut);
            errors++;
        end
        drain_line();
        respond("");
    endtask

    initial begin
        clrn = 1'b0;
        kbd_valid = 1'b0;
        kbd_ascii = 8'h00;
        lineOut_nextASCII = 1'b0;
        in_newASCII_ready = 1'b0;
        lineIn = 8'h00;
        in_solved = 1'b0;
        scr_ready = 1'b1;
        #1;
        test_reset();
        test_type_ab();
        test_backspace();
        test_empty_and_backpressure();
        test_overflow();
        test_response();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bash_line_port.md
BASH_LINE_PORT -- requirements
Module: bash_line_port

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32: line buffer depth including the 0x00 terminator, so at most MAX_LEN-1 text characters.
REQ-002 SHALL have port clk, in, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port clrn, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports kbd_valid (in, 1), kbd_ascii (in, 8) and kbd_ready (out, 1): keyboard byte strobe, keyboard byte, and key-accept enable.
REQ-005 SHALL have ports out_newASCII_ready (out, 1), lineOut (out, 8), out_lineLen (out, 6) and lineOut_nextASCII (in, 1): line-send handshake to the command stage.
REQ-006 SHALL have ports in_newASCII_ready (in, 1), lineIn (in, 8), lineIn_nextASCII (out, 1), in_solved (in, 1) and out_solved (out, 1): response-receive handshake from the command stage.
REQ-007 SHALL have ports scr_char (out, 8), scr_we (out, 1) and scr_ready (in, 1): character stream to the screen writer.

Function
REQ-008 SHALL implement states EDIT, SEND, WAIT_RESP and PRINT, plus PROMPT when REQ-021 applies.
REQ-009 SHALL drive kbd_ready = (state==EDIT) && scr_ready, and SHALL ignore kbd_valid whenever kbd_ready=0.
REQ-010 In EDIT, an accepted printable byte (0x20-0x7E) with len<MAX_LEN-1 SHALL be stored at buf[len], increment len, and echo as a 1-cycle scr_we with scr_char=byte.
REQ-011 In EDIT, a printable byte with len==MAX_LEN-1 SHALL be dropped with no echo.
REQ-012 In EDIT, 0x08 with len>0 SHALL decrement len and echo 0x08; 0x08 with len==0 SHALL be ignored.
REQ-013 In EDIT, 0x0D or 0x0A SHALL echo 0x0A, clear idx, and move to SEND next cycle; all other bytes SHALL be ignored.
REQ-014 In SEND:
- out_newASCII_ready=1.
- out_lineLen=len.
- lineOut = (idx<len) ? buf[idx] : 0x00.
- On a lineOut_nextASCII pulse: if idx<len then idx++; if idx==len then deassert out_newASCII_ready and enter WAIT_RESP.
REQ-015 In WAIT_RESP, in_newASCII_ready=1 SHALL move the block to PRINT on the next cycle.
REQ-016 In PRINT, when lineIn!=0x00, scr_ready=1, and lineIn_nextASCII was 0 last cycle, the block SHALL in the same cycle:
- set scr_we=1, scr_char=lineIn;
- set lineIn_nextASCII=1.
This caps the rate at one character per two cycles, giving the command stage one cycle to advance lineIn.
REQ-017 In PRINT, when in_solved=1, the block SHALL in the next cycle:
- pulse out_solved for exactly one cycle;
- emit scr_char=0x0A with scr_we=1;
- clear len;
- enter EDIT, or PROMPT if REQ-021 applies.
REQ-018 An empty line (Enter at len=0) SHALL send only 0x00 with out_lineLen=0 and then follow the normal WAIT_RESP/PRINT flow.
REQ-019 scr_we and lineIn_nextASCII SHALL be 1-cycle pulses, and scr_we SHALL never assert while scr_ready=0.

Reset
REQ-020 While clrn=0:
- all outputs SHALL be 0;
- len and idx SHALL be 0;
- state SHALL be EDIT, or PROMPT if REQ-021 applies;
- a mid-SEND or mid-PRINT transfer SHALL be abandoned with no further pulses after release.

Configuration
REQ-021 With BASH_PROMPT_EN defined, PROMPT SHALL emit 0x3E then 0x20 (each a scr_we pulse gated by scr_ready) and then enter EDIT; without it, PROMPT SHALL not exist and kbd_ready SHALL depend only on EDIT and scr_ready.

Structure
REQ-022 Package bash_io_pkg SHALL hold:
- the state enum;
- ASCII constants NUL, BS, LF, CR, PROMPT_CH;
- the default MAX_LEN.
REQ-023 Sub-module bash_line_buf SHALL hold the MAX_LEN x 8 storage plus the len counter, with push, pop and clear ports and a read-by-index port.

Verification
REQ-024 Type 'a','b',CR -> scr receives 0x61, 0x62, 0x0A; then out_lineLen=2 and lineOut sequence 0x61, 0x62, 0x00.
REQ-025 Type 'a','b','c',BS,CR -> scr receives 0x08 after 'c'; out_lineLen=2; lineOut sequence 0x61, 0x62, 0x00.
REQ-026 Type 35 printable characters then CR -> only the first 31 are echoed, and out_lineLen=31.
REQ-027 Command stage returns "hi" then 0x00 with in_solved -> scr receives 0x68, 0x69, 0x0A; out_solved is high exactly one cycle; state returns to EDIT.
REQ-028 Assert clrn mid-SEND at idx=1 -> out_newASCII_ready=0 immediately; after release len=0, and no lineOut_nextASCII-driven advance occurs.
REQ-029 With BASH_PROMPT_EN defined, after reset -> scr receives 0x3E, 0x20 before kbd_ready first rises; the same prompt appears after every out_solved.
